morty_csr_unit: RTL

//  Machine-mode CSR file and trap responder. Consumes the trap/CSR bundle the decode stage launches into the pipeline
//  (exception code, trap valid, exc data, xret, csr op/addr/data); sits at MEM. Commits traps, interrupts and mret,

---
 rtl/morty_csr_pkg.sv | 51 +++++
 rtl/morty_csr_if.sv | 34 +++
 rtl/morty_csr_counter.sv | 32 +++
 rtl/morty_csr_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/morty_csr_pkg.sv
// Shared constants for the machine-mode CSR unit: CSR addresses, csr_op
// encodings, trap codes, FSM states and the CSR read-modify-write helper.
package morty_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [2:0] CSR_OP_RW = 3'b001;
  localparam logic [2:0] CSR_OP_RS = 3'b010;
  localparam logic [2:0] CSR_OP_RC = 3'b011;

  localparam logic [3:0] EXC_MISALIGNED = 4'h0;
  localparam logic [3:0] EXC_ILLEGAL    = 4'h2;
  localparam logic [3:0] EXC_BREAK      = 4'h3;
  localparam logic [3:0] EXC_ECALL      = 4'hb;
  localparam logic [3:0] IRQ_MSI        = 4'd3;
  localparam logic [3:0] IRQ_MTI        = 4'd7;
  localparam logic [3:0] IRQ_MEI        = 4'd11;

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  typedef enum logic [1:0] {ST_IDLE, ST_TRAP, ST_XRET} state_e;

  // New CSR value for a read-modify-write op; non-ops leave the value alone.
  function automatic logic [31:0] csr_apply(input logic [2:0] op, input logic [31:0] old,
                                            input logic [31:0] d);
    case (op)
      CSR_OP_RW: csr_apply = d;
      CSR_OP_RS: csr_apply = old | d;
      CSR_OP_RC: csr_apply = old & ~d;
      default:   csr_apply = old;
    endcase
  endfunction

endpackage

// File: rtl/morty_csr_if.sv
// Trap/CSR bundle between the pipeline (master) and the CSR unit (slave).
interface morty_csr_if;
  logic        valid_i;
  logic        stall_i;
  logic [31:0] pc_i;
  logic [3:0]  exception_i;
  logic        trap_valid_i;
  logic [31:0] exc_data_i;
  logic        xret_op_i;
  logic [2:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic        retire_i;
  logic        irq_ext_i;
  logic        irq_timer_i;
  logic        irq_sw_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;

  modport master (
    output valid_i, stall_i, pc_i, exception_i, trap_valid_i, exc_data_i, xret_op_i,
           csr_op_i, csr_addr_i, csr_wdata_i, retire_i, irq_ext_i, irq_timer_i, irq_sw_i,
    input  csr_rdata_o, csr_illegal_o, redirect_o, redirect_pc_o, flush_o
  );

  modport slave (
    input  valid_i, stall_i, pc_i, exception_i, trap_valid_i, exc_data_i, xret_op_i,
           csr_op_i, csr_addr_i, csr_wdata_i, retire_i, irq_ext_i, irq_timer_i, irq_sw_i,
    output csr_rdata_o, csr_illegal_o, redirect_o, redirect_pc_o, flush_o
  );
endinterface

// File: rtl/morty_csr_counter.sv
// 64-bit event counter with separate low/high word write ports.
// A write to either half suppresses that cycle's increment.
module morty_csr_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);
  logic [63:0] cnt_q, cnt_d;

  // Next count: software write wins over the increment.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]  = wdata_i;
      if (wr_hi_i) cnt_d[63:32] = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/morty_csr_unit.sv
// Machine-mode CSR file and trap responder at MEM. Takes interrupts,
// exceptions and mret, serves CSR reads/writes, and pulses redirect/flush.
// Build option MORTY_CSR_COUNTERS_EN adds mcycle/minstret (and RO aliases).
import morty_csr_pkg::*;

module morty_csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] HART_ID     = 32'h0
) (
  input logic          clk_i,
  input logic          rst_i,
  morty_csr_if.slave   bus
);
  logic        mie_bit_q, mpie_q;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  state_e      state_q, state_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] mip, mstatus_rd, rdata, wval, irq_pend, trap_base, trap_vec;
  logic        addr_ok, addr_ro, op_active, wr_req, illegal;
  logic        commit, irq_any, take_irq, take_trap, take_xret, csr_we;
  logic [3:0]  irq_code;

  assign mip        = {20'b0, bus.irq_ext_i, 3'b0, bus.irq_timer_i, 3'b0, bus.irq_sw_i, 3'b0};
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_bit_q, 3'b0};

`ifdef MORTY_CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;

  morty_csr_counter u_mcycle (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(1'b1),
    .wr_lo_i(csr_we && bus.csr_addr_i == CSR_MCYCLE),
    .wr_hi_i(csr_we && bus.csr_addr_i == CSR_MCYCLEH),
    .wdata_i(wval), .cnt_o(mcycle)
  );

  morty_csr_counter u_minstret (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(bus.retire_i),
    .wr_lo_i(csr_we && bus.csr_addr_i == CSR_MINSTRET),
    .wr_hi_i(csr_we && bus.csr_addr_i == CSR_MINSTRETH),
    .wdata_i(wval), .cnt_o(minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = bus.retire_i;
`endif

  // CSR read mux plus address legality / read-only classification.
  always_comb begin
    rdata   = '0;
    addr_ok = 1'b1;
    addr_ro = 1'b0;
    case (bus.csr_addr_i)
      CSR_MSTATUS:  rdata = mstatus_rd;
      CSR_MISA:     begin rdata = MISA_VAL; addr_ro = 1'b1; end
      CSR_MIE:      rdata = mie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = mtval_q;
      CSR_MIP:      begin rdata = mip; addr_ro = 1'b1; end
      CSR_MHARTID:  begin rdata = HART_ID; addr_ro = 1'b1; end
`ifdef MORTY_CSR_COUNTERS_EN
      CSR_MCYCLE:    rdata = mcycle[31:0];
      CSR_MCYCLEH:   rdata = mcycle[63:32];
      CSR_MINSTRET:  rdata = minstret[31:0];
      CSR_MINSTRETH: rdata = minstret[63:32];
      CSR_CYCLE:     begin rdata = mcycle[31:0];    addr_ro = 1'b1; end
      CSR_CYCLEH:    begin rdata = mcycle[63:32];   addr_ro = 1'b1; end
      CSR_INSTRET:   begin rdata = minstret[31:0];  addr_ro = 1'b1; end
      CSR_INSTRETH:  begin rdata = minstret[63:32]; addr_ro = 1'b1; end
`else
      // Counters absent: addresses stay legal, read zero, writes are dropped.
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: rdata = '0;
`endif
      default:      addr_ok = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so reading an RO CSR stays legal.
  assign op_active = (bus.csr_op_i == CSR_OP_RW) || (bus.csr_op_i == CSR_OP_RS) ||
                     (bus.csr_op_i == CSR_OP_RC);
  assign wr_req    = (bus.csr_op_i == CSR_OP_RW) || (op_active && bus.csr_wdata_i != '0);
  assign illegal   = bus.valid_i && op_active && (!addr_ok || (addr_ro && wr_req));
  assign wval      = csr_apply(bus.csr_op_i, rdata, bus.csr_wdata_i);

  // Commit decision with priority interrupt > exception > mret > CSR write.
  assign irq_pend  = mie_q & mip;
  assign irq_any   = mie_bit_q && (irq_pend[11] || irq_pend[7] || irq_pend[3]);
  assign irq_code  = irq_pend[11] ? IRQ_MEI : (irq_pend[3] ? IRQ_MSI : IRQ_MTI);
  assign commit    = bus.valid_i && !bus.stall_i && state_q == ST_IDLE;
  assign take_irq  = commit && irq_any;
  assign take_trap = commit && (irq_any || bus.trap_valid_i);
  assign take_xret = commit && !irq_any && !bus.trap_valid_i && bus.xret_op_i;
  assign csr_we    = commit && !irq_any && !bus.trap_valid_i && !bus.xret_op_i &&
                     wr_req && !illegal;

  // Vectored mode only offsets interrupts; exceptions always go to the base.
  assign trap_base = mtvec_q & 32'hFFFF_FFFC;
  assign trap_vec  = (mtvec_q[0] && take_irq) ? trap_base + {26'b0, irq_code, 2'b00} : trap_base;

  // FSM next state and redirect target latched on entry to TRAP/XRET.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (take_trap) begin
          state_d       = ST_TRAP;
          redirect_pc_d = trap_vec;
        end else if (take_xret) begin
          state_d       = ST_XRET;
          redirect_pc_d = mepc_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and redirect target registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Architectural CSR updates: trap entry, mret, then software writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mie_bit_q  <= 1'b0;
      mpie_q     <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (take_trap) begin
      mepc_q    <= bus.pc_i & 32'hFFFF_FFFC;
      mcause_q  <= take_irq ? {1'b1, 27'b0, irq_code} : {28'b0, bus.exception_i};
      mtval_q   <= take_irq ? 32'h0 : bus.exc_data_i;
      mpie_q    <= mie_bit_q;
      mie_bit_q <= 1'b0;
    end else if (take_xret) begin
      mie_bit_q <= mpie_q;
      mpie_q    <= 1'b1;
    end else if (csr_we) begin
      case (bus.csr_addr_i)
        CSR_MSTATUS:  begin mie_bit_q <= wval[3]; mpie_q <= wval[7]; end
        CSR_MIE:      mie_q      <= wval;
        CSR_MTVEC:    mtvec_q    <= wval;
        CSR_MSCRATCH: mscratch_q <= wval;
        CSR_MEPC:     mepc_q     <= wval & 32'hFFFF_FFFC;
        CSR_MCAUSE:   mcause_q   <= wval;
        CSR_MTVAL:    mtval_q    <= wval;
        default:      ;
      endcase
    end
  end

  assign bus.csr_rdata_o   = rdata;
  assign bus.csr_illegal_o = illegal;
  assign bus.redirect_o    = state_q != ST_IDLE;
  assign bus.flush_o       = state_q != ST_IDLE;
  assign bus.redirect_pc_o = redirect_pc_q;
endmodule
